// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the round-robin FIFO read scheduler.
//  sched_state_t : IDLE (no grant last load cycle) / BURST (a source is being drained)
//  SRC_W         : source index width for the default four-source configuration
//  src_width()   : index width for an arbitrary count, never narrower than 1 bit
package fifo_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int SRC_W           = $clog2(NUM_REQ_DEFAULT);

  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//  req     in   NUM_REQ  request vector (bit i = source i wants service)
//  base    in   SW       last served index; search starts at base+1
//  idx     out  SW       first requesting index in base+1, base+2, ... base (wrapping)
//  any_req out  1        at least one request bit is set
// When nothing is requested idx is base and any_req is 0.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SW      = SRC_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SW-1:0]      base,
  output logic [SW-1:0]      idx,
  output logic               any_req
);

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] b, input int k);
    int s;
    s = (int'(b) + k) % NUM_REQ;
    return SW'(s);
  endfunction

  // Walk the candidates from farthest (base itself) to nearest (base+1) so the
  // nearest requesting source is the last one written and therefore wins.
  always_comb begin
    logic [SW-1:0] pos;
    idx     = base;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = wrap_add(base, k);
      if (req[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler draining NUM_REQ show-ahead FIFOs into one
// registered valid/ready stream, with bounded bursts per source.
// Ports:
//  clk         in   1                clock
//  reset       in   1                synchronous active-high reset
//  empty_in    in   NUM_REQ          empty flag of FIFO i
//  data_in     in   NUM_REQ*W        head word of FIFO i at [i*W +: W]
//  read_out    out  NUM_REQ          read strobe to FIFO i (one-hot or zero)
//  out_valid   out  1                output word valid
//  out_data    out  W                output word
//  out_src     out  clog2(NUM_REQ)   FIFO index that supplied out_data
//  out_ready   in   1                consumer accepts when out_valid && out_ready
//  flush_in    in   1                drop held word, go idle
//  debugen_in  in   1                print one line per grant
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH_BYTES = 4,
  parameter int MAX_BURST   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              empty_in,
  input  logic [NUM_REQ*WIDTH_BYTES*8-1:0] data_in,
  output logic [NUM_REQ-1:0]              read_out,
  output logic                            out_valid,
  output logic [WIDTH_BYTES*8-1:0]        out_data,
  output logic [$clog2(NUM_REQ)-1:0]      out_src,
  input  logic                            out_ready,
  input  logic                            flush_in,
  input  logic                            debugen_in
);

  localparam int W  = WIDTH_BYTES * 8;
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = src_width(MAX_BURST);  // burst_cnt tops out at MAX_BURST-1

  sched_state_t   state_reg, state_next;
  logic [SW-1:0]  ptr_reg;
  logic [CW-1:0]  burst_cnt_reg;
  logic           out_valid_reg;
  logic [W-1:0]   out_data_reg;
  logic [SW-1:0]  out_src_reg;

  logic           load;
  logic           cont_burst;
  logic           grant;
  logic           any_req;
  logic [SW-1:0]  pick_idx;
  logic [SW-1:0]  grant_idx;
  logic [W-1:0]   head [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SW      (SW)
  ) u_pick (
    .req     (~empty_in),
    .base    (ptr_reg),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign head[gi]     = data_in[gi*W +: W];
      assign read_out[gi] = grant && (grant_idx == SW'(gi));
    end
  endgenerate

  // out_ready feeds read_out combinationally so a word can be replaced in the
  // same cycle it is consumed, sustaining one word per cycle.
  always_comb begin
    load       = !out_valid_reg || out_ready;
    cont_burst = (state_reg == BURST) && !empty_in[ptr_reg] &&
                 ((32'(burst_cnt_reg) + 32'd1) < 32'(MAX_BURST));
    grant_idx  = cont_burst ? ptr_reg : pick_idx;
    grant      = load && any_req && !flush_in && !reset;

    state_next = state_reg;
    if (flush_in) begin
      state_next = IDLE;
    end else if (load) begin
      state_next = grant ? BURST : IDLE;
    end
  end

  task update_regs();
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= SW'(NUM_REQ - 1);  // first search then starts at source 0
      burst_cnt_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (flush_in) begin
        // out_data/out_src intentionally keep their stale contents
        out_valid_reg <= 1'b0;
        burst_cnt_reg <= '0;
      end else if (load) begin
        out_valid_reg <= grant;
        if (grant) begin
          out_data_reg <= head[grant_idx];
          out_src_reg  <= grant_idx;
          if (cont_burst) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
          end else begin
            // new source, or the same one restarting after hitting the limit
            ptr_reg       <= grant_idx;
            burst_cnt_reg <= '0;
          end
          if (debugen_in) begin
            $write("fifo_rr_sched: grant src=%0d data=%h\n", grant_idx, head[grant_idx]);
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    update_regs();
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

`ifndef SYNTHESIS
  a_read_onehot: assert property (@(posedge clk) $onehot0(read_out));
  a_read_nonempty: assert property (@(posedge clk) (read_out & empty_in) == '0);
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush_in) |=>
      (out_valid && $stable(out_data) && $stable(out_src)));
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: two scheduler instances (MAX_BURST=1 and 4) share
// four behavioural show-ahead FIFOs; only the selected one is out of reset.
module tb_fifo_rr_sched;

  localparam int NR    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } word_t;

  typedef struct {
    word_t w;
    int    cyc;
  } got_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset     = 1'b1;
  logic sel       = 1'b0;
  logic flush_in  = 1'b0;
  logic out_ready = 1'b1;

  logic            rst_a, rst_b;
  logic [NR-1:0]   empty_in;
  logic [NR*W-1:0] data_in;
  logic [NR-1:0]   rd_a, rd_b, read_out;
  logic            va, vb, out_valid;
  logic [W-1:0]    da, db, out_data;
  logic [1:0]      sa, sb_src, out_src;

  int total = 0;
  int bad   = 0;

  assign rst_a     = reset || sel;
  assign rst_b     = reset || !sel;
  assign read_out  = sel ? rd_b : rd_a;
  assign out_valid = sel ? vb : va;
  assign out_data  = sel ? db : da;
  assign out_src   = sel ? sb_src : sa;

  fifo_rr_sched #(.NUM_REQ(NR), .WIDTH_BYTES(4), .MAX_BURST(1)) u_rr (
    .clk(clk), .reset(rst_a), .empty_in(empty_in), .data_in(data_in),
    .read_out(rd_a), .out_valid(va), .out_data(da), .out_src(sa),
    .out_ready(out_ready), .flush_in(flush_in), .debugen_in(1'b0));

  fifo_rr_sched #(.NUM_REQ(NR), .WIDTH_BYTES(4), .MAX_BURST(4)) u_bu (
    .clk(clk), .reset(rst_b), .empty_in(empty_in), .data_in(data_in),
    .read_out(rd_b), .out_valid(vb), .out_data(db), .out_src(sb_src),
    .out_ready(out_ready), .flush_in(flush_in), .debugen_in(1'b0));

  // ---------------- show-ahead FIFOs (depth 8) ----------------
  logic [W-1:0] mem [NR][DEPTH];
  logic [2:0]   wr_ptr [NR] = '{default: 3'd0};
  logic [2:0]   rd_ptr [NR] = '{default: 3'd0};
  int           wr_cnt [NR] = '{default: 0};
  int           rd_cnt [NR] = '{default: 0};

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_fifo
      assign empty_in[gi]          = (wr_cnt[gi] == rd_cnt[gi]);
      assign data_in[gi*W +: W]    = mem[gi][rd_ptr[gi]];
    end
  endgenerate

  function automatic int occ(input int i);
    return wr_cnt[i] - rd_cnt[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (read_out[i]) begin
        total++;
        if (wr_cnt[i] == rd_cnt[i]) begin
          bad++;
          $display("FAIL fifo_read_empty: fifo %0d strobed with occupancy 0, required no read", i);
        end else begin
          rd_cnt[i] <= rd_cnt[i] + 1;
          rd_ptr[i] <= rd_ptr[i] + 3'd1;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard push ----------------
  // Per load cycle: keep serving the current source while it has data and
  // has had fewer than MAX_BURST consecutive grants; otherwise hand the turn
  // to the next non-empty source after it in circular order.
  word_t       sb[$];
  int          m_ptr    = NR - 1;
  int          m_run    = 0;
  bit          m_active = 1'b0;
  bit          m_valid  = 1'b0;
  logic [NR-1:0] m_exp_rd;
  int          m_g;
  int          m_mb;

  always @(posedge clk) begin
    m_exp_rd = '0;
    m_mb     = sel ? 4 : 1;
    if (reset) begin
      m_ptr = NR - 1; m_run = 0; m_active = 1'b0; m_valid = 1'b0;
      sb.delete();
    end else if (flush_in) begin
      m_valid = 1'b0; m_active = 1'b0; m_run = 0;
      sb.delete();
    end else if (!m_valid || out_ready) begin
      m_g = -1;
      if (m_active && occ(m_ptr) > 0 && m_run < m_mb) begin
        m_g = m_ptr;
        m_run++;
      end else begin
        for (int k = 1; k <= NR; k++)
          if (m_g < 0 && occ((m_ptr + k) % NR) > 0) m_g = (m_ptr + k) % NR;
        if (m_g >= 0) begin
          m_ptr = m_g;
          m_run = 1;
        end
      end
      if (m_g >= 0) begin
        m_exp_rd[m_g] = 1'b1;
        sb.push_back('{src: 2'(m_g), data: mem[m_g][rd_ptr[m_g]]});
        m_valid  = 1'b1;
        m_active = 1'b1;
      end else begin
        m_valid  = 1'b0;
        m_active = 1'b0;
      end
    end
    total++;
    if (read_out !== m_exp_rd) begin
      bad++;
      $display("FAIL read_strobe: read_out=%b required %b", read_out, m_exp_rd);
    end
  end

  // ---------------- monitor: compare and pop ----------------
  got_t got[$];
  int   ncyc = 0;
  word_t popped;

  always @(negedge clk) begin
    ncyc++;
    total++;
    if (out_valid !== (sb.size() != 0)) begin
      bad++;
      $display("FAIL out_valid: got %b required %b", out_valid, sb.size() != 0);
    end
    if (out_valid === 1'b1 && sb.size() != 0) begin
      total++;
      if ({out_src, out_data} !== sb[0]) begin
        bad++;
        $display("FAIL out_word: got src=%0d data=%h required src=%0d data=%h",
                 out_src, out_data, sb[0].src, sb[0].data);
      end
      if (out_ready) begin
        popped = sb.pop_front();
        got.push_back('{w: popped, cyc: ncyc});
        $display("accept cyc=%0d src=%0d data=%h", ncyc, out_src, out_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] d);
    if (occ(i) < DEPTH) begin
      mem[i][wr_ptr[i]] = d;
      wr_ptr[i] = wr_ptr[i] + 3'd1;
      wr_cnt[i]++;
    end
  endtask

  task automatic start(input bit s);
    reset = 1'b1; flush_in = 1'b0; out_ready = 1'b1;
    cyc();
    sel = s;
    for (int i = 0; i < NR; i++) begin
      wr_cnt[i] = rd_cnt[i];
      wr_ptr[i] = rd_ptr[i];
    end
    got.delete();
  endtask

  function automatic int fifo_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += occ(i);
    return s;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((fifo_total() > 0 || out_valid || sb.size() > 0) && n < budget) begin
      cyc();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: out_valid low for %0d cycles, required high", name, n);
    end
  endtask

  // ---------------- scenarios ----------------
  logic [W-1:0] hold_d;
  logic [1:0]   hold_s;
  int           occ_snap, rd_snap;
  int           exp_src3 [8] = '{0, 0, 0, 0, 2, 2, 0, 0};

  initial begin
    // 1: reset held with loaded FIFOs; 2: MAX_BURST=1 round robin drains them
    start(1'b0);
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 2; j++) push(i, 32'(16 * i + j));
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("reset_read_out", 64'(read_out), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_src", 64'(out_src), 64'd0);
      chk("reset_out_data", 64'(out_data), 64'd0);
    end
    reset = 1'b0;
    wait_drain("rr", 40);
    chk("rr_count", 64'(got.size()), 64'd8);
    if (got.size() == 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("rr_data%0d", k), 64'(got[k].w.data), 64'(16 * (k % 4) + k / 4));
      chk("rr_no_bubble", 64'(got[7].cyc - got[0].cyc), 64'd7);
    end

    // 3: burst of four from FIFO0, then FIFO2, then FIFO0 again
    start(1'b1);
    for (int j = 0; j < 6; j++) push(0, 32'h100 + 32'(j));
    for (int j = 0; j < 2; j++) push(2, 32'h300 + 32'(j));
    reset = 1'b0;
    wait_drain("burst", 40);
    chk("burst_count", 64'(got.size()), 64'd8);
    if (got.size() == 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("burst_src%0d", k), 64'(got[k].w.src), 64'(exp_src3[k]));
      chk("burst_no_bubble", 64'(got[7].cyc - got[0].cyc), 64'd7);
    end

    // 4: backpressure right after the first word
    start(1'b1);
    for (int j = 0; j < 4; j++) push(1, 32'h500 + 32'(j));
    reset = 1'b0;
    wait_valid("bp", 10);
    out_ready = 1'b0;
    hold_d = out_data; hold_s = out_src; occ_snap = occ(1);
    chk("bp_first_data", 64'(hold_d), 64'h500);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'(hold_d));
      chk("bp_src", 64'(out_src), 64'(hold_s));
      chk("bp_read_out", 64'(read_out), 64'd0);
      chk("bp_occupancy", 64'(occ(1)), 64'(occ_snap));
    end
    out_ready = 1'b1;
    wait_drain("bp", 40);
    chk("bp_count", 64'(got.size()), 64'd4);
    if (got.size() == 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("bp_order%0d", k), 64'(got[k].w.data), 64'h500 + 64'(k));

    // 5: single word in FIFO3
    start(1'b1);
    push(3, 32'h3ab);
    reset = 1'b0;
    rd_snap = rd_cnt[3];
    wait_drain("single", 20);
    chk("single_reads", 64'(rd_cnt[3] - rd_snap), 64'd1);
    chk("single_valid_drop", 64'(out_valid), 64'd0);
    chk("single_count", 64'(got.size()), 64'd1);

    // 6: flush while a word is held under backpressure
    start(1'b1);
    push(0, 32'h600); push(0, 32'h601);
    push(1, 32'h610); push(1, 32'h611);
    out_ready = 1'b0;
    reset = 1'b0;
    wait_valid("flush", 10);
    chk("flush_pre_src", 64'(out_src), 64'd0);
    flush_in = 1'b1;
    #1;
    chk("flush_read_out", 64'(read_out), 64'd0);
    cyc();
    flush_in = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    wait_drain("flush", 40);
    chk("flush_count", 64'(got.size()), 64'd3);
    if (got.size() != 0) begin
      chk("flush_next_src", 64'(got[0].w.src), 64'd1);
      chk("flush_next_data", 64'(got[0].w.data), 64'h610);
    end

    // random traffic against the model on both burst settings
    for (int it = 0; it < 6; it++) begin
      start(1'(it % 2));
      reset = 1'b0;
      for (int c = 0; c < 300; c++) begin
        cyc();
        for (int i = 0; i < NR; i++)
          if ($urandom_range(0, 2) == 0) push(i, {8'(i), 24'($urandom)});
        out_ready = ($urandom_range(0, 3) != 0);
        flush_in  = ($urandom_range(0, 31) == 0);
        reset     = ($urandom_range(0, 149) == 0);
      end
      cyc();
      reset = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
      wait_drain("random", 200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
